mux_nx1_scan: RTL and testbench

Parameterised, registered N-to-1 multiplexer with a valid/ready output stage and an automatic channel-scan mode. It selects one WIDTH-bit lane out of CHANNELS packed input lanes, either by a direct select input or by a round-robin scan pointer that skips masked-off channels. It sits between a bank of parallel sample sources and a single downstream serial consumer, tagging every output sample with its channel number.

---
 rtl/mux_nx1_scan.sv | 134 +++++++++++++
 tb/tb_mux_nx1_scan.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_scan.sv
// Registered N-to-1 lane multiplexer with a valid/ready output stage.
// A lane is chosen by a direct select, or by a round-robin scan that
// skips masked-off channels. Every output sample carries its channel.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   data_in    CHANNELS packed lanes, lane k = data_in[k*WIDTH +: WIDTH]
//   sel        manual channel select (mode = 0)
//   mode       0 = manual select, 1 = auto scan
//   ch_en      scan enable mask, bit k lets channel k be scanned
//   out_data   registered sample
//   out_ch     channel index of out_data
//   out_valid  sample held and not yet accepted
//   out_ready  downstream accepts when out_valid && out_ready
//   scan_done  one-cycle pulse when the scan pointer wraps after a capture
module mux_nx1_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       ch_en,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      scan_done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic [SEL_W-1:0] nxt_ptr;
    logic             nxt_found;

    // Lane lookup; indices outside the populated range read as zero.
    function automatic logic [WIDTH-1:0] lane_of(
        input logic [CHANNELS*WIDTH-1:0] din,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == idx) begin
                v = din[k*WIDTH +: WIDTH];
            end
        end
        return v;
    endfunction

    // Next enabled channel strictly after ptr_q, searched circularly.
    // When ptr_q is the only enabled channel the search lands on itself.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        nxt_found = 1'b0;
        nxt_ptr   = ptr_q;
        idx       = 0;
        idx_s     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx   = (int'(ptr_q) + i) % CHANNELS;
            idx_s = SEL_W'(idx);
            if (!nxt_found && ch_en[idx_s]) begin
                nxt_found = 1'b1;
                nxt_ptr   = idx_s;
            end
        end
    end

    assign load = !valid_q || out_ready;

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        if (load) begin
            if (!mode) begin
                ch_d    = sel;
                valid_d = 1'b1;
                if (int'(sel) < CHANNELS) begin
                    data_d = lane_of(data_in, sel);
                end else begin
                    data_d = '0;
                end
            end else if (nxt_found) begin
                ptr_d = nxt_ptr;
                if (ch_en[ptr_q]) begin
                    data_d  = lane_of(data_in, ptr_q);
                    ch_d    = ptr_q;
                    valid_d = 1'b1;
                    // Wrap includes the single-enabled-channel case.
                    done_d  = (nxt_ptr <= ptr_q);
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed vector bench for mux_nx1_scan: 8-lane main instance plus a
// 5-lane instance for out-of-range select and non-power-of-two wrap.
module tb_mux_nx1_scan;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] ch_en;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       edone;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  ch_en;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        scan_done;

    logic [39:0] data_in2;
    logic [2:0]  sel2;
    logic        mode2;
    logic [4:0]  ch_en2;
    logic [7:0]  out_data2;
    logic [2:0]  out_ch2;
    logic        out_valid2;
    logic        out_ready2;
    logic        scan_done2;

    int checks = 0;
    int fails  = 0;
    vec_t vq[$];

    mux_nx1_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
        .mode(mode), .ch_en(ch_en), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .scan_done(scan_done)
    );

    mux_nx1_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in2), .sel(sel2),
        .mode(mode2), .ch_en(ch_en2), .out_data(out_data2),
        .out_ch(out_ch2), .out_valid(out_valid2),
        .out_ready(out_ready2), .scan_done(scan_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [2:0] s,
                       input logic [7:0] en, input logic rd,
                       input logic ev, input logic [7:0] ed,
                       input logic [2:0] ec, input logic edn);
        vec_t v;
        v.rst = r; v.mode = m; v.sel = s; v.ch_en = en; v.rdy = rd;
        v.ev = ev; v.ed = ed; v.ec = ec; v.edone = edn;
        vq.push_back(v);
    endtask

    task automatic chk_main(input string tag, input logic ev,
                            input logic [7:0] ed, input logic [2:0] ec,
                            input logic edn);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_data"},  32'(out_data),  32'(ed));
        chk({tag, "_ch"},    32'(out_ch),    32'(ec));
        chk({tag, "_done"},  32'(scan_done), 32'(edn));
    endtask

    task automatic chk_two(input string tag, input logic ev,
                           input logic [7:0] ed, input logic [2:0] ec,
                           input logic edn);
        chk({tag, "_valid"}, 32'(out_valid2), 32'(ev));
        chk({tag, "_data"},  32'(out_data2),  32'(ed));
        chk({tag, "_ch"},    32'(out_ch2),    32'(ec));
        chk({tag, "_done"},  32'(scan_done2), 32'(edn));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) data_in[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 5; k++) data_in2[k*8 +: 8] = 8'(8'h10 + k);
        rst = 1'b1; sel = '0; mode = 1'b0; ch_en = '0; out_ready = 1'b0;
        sel2 = '0; mode2 = 1'b0; ch_en2 = '0; out_ready2 = 1'b1;

        // reset held three cycles
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // manual sweep
        for (int s = 0; s < 8; s++)
            add(0, 0, 3'(s), 8'h00, 1, 1, 8'(8'h10 + s), 3'(s), 0);
        // scan with mask 1010_0101: 0,2,5,7(wrap),0,2
        add(0, 1, 0, 8'hA5, 1, 1, 8'h10, 0, 0);
        add(0, 1, 0, 8'hA5, 1, 1, 8'h12, 2, 0);
        add(0, 1, 0, 8'hA5, 1, 1, 8'h15, 5, 0);
        add(0, 1, 0, 8'hA5, 1, 1, 8'h17, 7, 1);
        add(0, 1, 0, 8'hA5, 1, 1, 8'h10, 0, 0);
        add(0, 1, 0, 8'hA5, 1, 1, 8'h12, 2, 0);
        // all enabled, ptr now 5: 5,6,7(wrap),0,1,2,3
        add(0, 1, 0, 8'hFF, 1, 1, 8'h15, 5, 0);
        add(0, 1, 0, 8'hFF, 1, 1, 8'h16, 6, 0);
        add(0, 1, 0, 8'hFF, 1, 1, 8'h17, 7, 1);
        for (int c = 0; c < 4; c++)
            add(0, 1, 0, 8'hFF, 1, 1, 8'(8'h10 + c), 3'(c), 0);
        // stall 4 cycles at ch 3; mask change must not be seen
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 8'h00, 0, 1, 8'h13, 3, 0);
        add(0, 1, 0, 8'hFF, 1, 1, 8'h14, 4, 0);
        add(0, 1, 0, 8'hFF, 1, 1, 8'h15, 5, 0);
        // empty mask: valid drops, ptr holds at 6
        add(0, 1, 0, 8'h00, 1, 0, 8'h15, 5, 0);
        add(0, 1, 0, 8'h00, 1, 0, 8'h15, 5, 0);
        // single channel 4: bubble from ptr 6, then 4 with done every time
        add(0, 1, 0, 8'h10, 1, 0, 8'h15, 5, 0);
        add(0, 1, 0, 8'h10, 1, 1, 8'h14, 4, 1);
        add(0, 1, 0, 8'h10, 1, 1, 8'h14, 4, 1);

        foreach (vq[i]) begin
            rst = vq[i].rst; mode = vq[i].mode; sel = vq[i].sel;
            ch_en = vq[i].ch_en; out_ready = vq[i].rdy;
            @(posedge clk); #1;
            chk_main($sformatf("v%0d", i), vq[i].ev, vq[i].ed,
                     vq[i].ec, vq[i].edone);
        end

        // reset mid-stall
        ch_en = 8'hFF; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_main("stall_hold", 1, 8'h14, 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_main("rst_stall", 0, 8'h00, 0, 0);
        rst = 1'b0; out_ready = 1'b1; ch_en = 8'h24;
        @(posedge clk); #1;
        chk_main("rst_bubble", 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        chk_main("rst_first", 1, 8'h12, 2, 0);
        @(posedge clk); #1;
        chk_main("rst_wrap", 1, 8'h15, 5, 1);

        // 5-lane instance: out-of-range select, then scan wrap at 4
        sel2 = 3'd6;
        @(posedge clk); #1;
        chk_two("c5_oor", 1, 8'h00, 6, 0);
        sel2 = 3'd4;
        @(posedge clk); #1;
        chk_two("c5_sel4", 1, 8'h14, 4, 0);
        mode2 = 1'b1; ch_en2 = 5'b10001;
        @(posedge clk); #1;
        chk_two("c5_scan0", 1, 8'h10, 0, 0);
        @(posedge clk); #1;
        chk_two("c5_scan4", 1, 8'h14, 4, 1);
        @(posedge clk); #1;
        chk_two("c5_scan0b", 1, 8'h10, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
